// File: rtl/input_conditioner_if.sv
// Pin-side and core-side signals of the input conditioner, grouped as one bundle.
// master drives the raw pins and observes the cleaned outputs; slave is the conditioner.
// WIDTH must match the WIDTH of the input_conditioner instance it connects to.
interface input_conditioner_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] raw_buttons;
    logic             raw_start;
    logic [WIDTH-1:0] buttons;
    logic [WIDTH-1:0] press_pulse;
    logic             start_pulse;
    logic             holdoff_active;

    modport master (
        output raw_buttons,
        output raw_start,
        input  buttons,
        input  press_pulse,
        input  start_pulse,
        input  holdoff_active
    );

    modport slave (
        input  raw_buttons,
        input  raw_start,
        output buttons,
        output press_pulse,
        output start_pulse,
        output holdoff_active
    );
endinterface

// File: rtl/input_conditioner.sv
// Purpose: synchronise + debounce WIDTH buttons and a start pin; emit press pulses and a hold-off protected start pulse.
// Latency: raw edge first sampled at E0 -> clean level / pulse registered at edge E0+DEBOUNCE+1.
// Backpressure: none; free-running sampler, outputs are registered levels/pulses consumed every cycle.
module input_conditioner #(
    parameter int WIDTH    = 8,   // number of main button channels
    parameter int DEBOUNCE = 4,   // consecutive differing cycles to change a clean level, 1..255
    parameter int HOLDOFF  = 16   // cycles after a start pulse that ignore new starts, 0..65535
) (
    input  logic               clock,
    input  logic               reset,
    input_conditioner_if.slave io
);

    // Channels 0..WIDTH-1 are the buttons, channel WIDTH is the start pin.
    localparam int NCH = WIDTH + 1;
    localparam int SCH = WIDTH;

    localparam int              CW       = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE - 1);

    // Hold-off counter needs at least one bit even when HOLDOFF is 0.
    localparam int              HW        = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLDOFF);
    localparam bit              HOLD_EN   = (HOLDOFF > 0);

    logic [NCH-1:0]   w_raw;
    logic [NCH-1:0]   r_sync1;
    logic [NCH-1:0]   r_sync2;
    logic [NCH-1:0]   r_clean;
    logic [CW-1:0]    r_cnt [NCH];
    logic [NCH-1:0]   w_accept;
    logic [NCH-1:0]   w_rise;
    logic [WIDTH-1:0] r_press;
    logic             w_start_fire;
    logic             r_start_pulse;
    logic             r_hold_active;
    logic [HW-1:0]    r_hold_cnt;

    assign w_raw = {io.raw_start, io.raw_buttons};

    // Two-flop synchroniser on every raw pin; nothing downstream sees r_sync1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // A channel flips its clean level on the DEBOUNCE-th consecutive mismatching cycle.
    always_comb begin
        w_accept = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            w_accept[ch] = (r_sync2[ch] != r_clean[ch]) && (r_cnt[ch] == CNT_LAST);
        end
    end

    // Only 0->1 acceptances generate pulses; releases are debounced but silent.
    assign w_rise = w_accept & r_sync2;

    // Debounce counters: any agreeing cycle restarts the count, so short glitches leave clean untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NCH; ch++) begin
                r_cnt[ch] <= '0;
            end
            r_clean <= '0;
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (r_sync2[ch] == r_clean[ch]) begin
                    r_cnt[ch] <= '0;
                end else if (r_cnt[ch] == CNT_LAST) begin
                    r_clean[ch] <= r_sync2[ch];
                    r_cnt[ch]   <= '0;
                end else begin
                    r_cnt[ch] <= r_cnt[ch] + 1'b1;
                end
            end
        end
    end

    // Press pulses are registered on the same edge that raises the clean level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_press <= '0;
        end else begin
            r_press <= w_rise[WIDTH-1:0];
        end
    end

    // A clean start rise is honoured only when the hold-off window has fully expired.
    assign w_start_fire = w_rise[SCH] && (r_hold_cnt == '0);

    // Start pulse and hold-off window; rises inside the window are dropped, not queued.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_start_pulse <= 1'b0;
            r_hold_cnt    <= '0;
            r_hold_active <= 1'b0;
        end else begin
            r_start_pulse <= w_start_fire;
            if (w_start_fire) begin
                r_hold_cnt    <= HOLD_LOAD;
                r_hold_active <= HOLD_EN;
            end else if (r_hold_cnt != '0) begin
                r_hold_cnt    <= r_hold_cnt - 1'b1;
                // Track the post-decrement value so the flag drops on the edge the count hits 0.
                r_hold_active <= (r_hold_cnt != HW'(1));
            end
        end
    end

    assign io.buttons        = r_clean[WIDTH-1:0];
    assign io.press_pulse    = r_press;
    assign io.start_pulse    = r_start_pulse;
    assign io.holdoff_active = r_hold_active;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus randomized bouncing inputs
// compared against a window-based reference model of the debounce and hold-off rules.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_input_conditioner;

    localparam int WIDTH    = 8;
    localparam int DEBOUNCE = 4;
    localparam int HOLDOFF  = 16;
    localparam int NCH      = WIDTH + 1;
    localparam int HL       = DEBOUNCE + 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    input_conditioner_if #(.WIDTH(WIDTH)) io ();

    input_conditioner #(
        .WIDTH    (WIDTH),
        .DEBOUNCE (DEBOUNCE),
        .HOLDOFF  (HOLDOFF)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io    (io)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // m_hist[k] = raw value sampled k edges ago. A channel's clean level flips when the
    // DEBOUNCE samples that have crossed the synchroniser all disagree with it.
    logic [NCH-1:0]   m_hist [HL];
    logic [NCH-1:0]   m_clean = '0;
    logic [NCH-1:0]   m_rise;
    logic [WIDTH-1:0] m_press = '0;
    logic             m_start = 1'b0;
    logic             m_hold  = 1'b0;
    bit               m_diff;
    bit               m_have  = 1'b0;
    int               m_cyc   = 0;
    int               m_last  = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < HL; k++) m_hist[k] = '0;
            m_clean = '0;
            m_press = '0;
            m_start = 1'b0;
            m_hold  = 1'b0;
            m_have  = 1'b0;
            m_cyc   = 0;
            m_last  = 0;
        end else begin
            for (int k = HL - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = {io.raw_start, io.raw_buttons};
            m_rise = '0;
            for (int c = 0; c < NCH; c++) begin
                m_diff = 1'b1;
                for (int j = 0; j < DEBOUNCE; j++)
                    if (m_hist[2+j][c] == m_clean[c]) m_diff = 1'b0;
                if (m_diff) begin
                    m_clean[c] = ~m_clean[c];
                    m_rise[c]  = m_clean[c];
                end
            end
            m_press = m_rise[WIDTH-1:0];
            m_cyc   = m_cyc + 1;
            m_start = 1'b0;
            if (m_rise[WIDTH] && (!m_have || (m_cyc - m_last) > HOLDOFF)) begin
                m_start = 1'b1;
                m_have  = 1'b1;
                m_last  = m_cyc;
            end
            m_hold = m_have && ((m_cyc - m_last) < HOLDOFF);
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b1;
        io.raw_buttons = '1;
        io.raw_start   = 1'b1;
        repeat (8) @(negedge clock);
        n_chk++; if (io.buttons !== 8'h00) begin n_err++; $display("FAIL reset.buttons got=%h want=00", io.buttons); end
        n_chk++; if (io.press_pulse !== 8'h00) begin n_err++; $display("FAIL reset.press got=%h want=00", io.press_pulse); end
        n_chk++; if (io.start_pulse !== 1'b0) begin n_err++; $display("FAIL reset.start got=%b want=0", io.start_pulse); end
        n_chk++; if (io.holdoff_active !== 1'b0) begin n_err++; $display("FAIL reset.holdoff got=%b want=0", io.holdoff_active); end
        io.raw_buttons = '0;
        io.raw_start   = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        n_chk++; if (io.buttons !== 8'h00) begin n_err++; $display("FAIL reset.idle_buttons got=%h want=00", io.buttons); end
    endtask

    task automatic test_clean_press;
        logic [7:0] eb, ep;
        io.raw_buttons = 8'h01;
        for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            eb = (t >= 5) ? 8'h01 : 8'h00;
            ep = (t == 5) ? 8'h01 : 8'h00;
            n_chk++; if (io.buttons !== eb) begin n_err++; $display("FAIL press.buttons t=%0d got=%h want=%h", t, io.buttons, eb); end
            n_chk++; if (io.press_pulse !== ep) begin n_err++; $display("FAIL press.pulse t=%0d got=%h want=%h", t, io.press_pulse, ep); end
        end
        io.raw_buttons = 8'h00;
        for (int t = 0; t < 10; t++) begin
            @(negedge clock);
            eb = (t >= 5) ? 8'h00 : 8'h01;
            n_chk++; if (io.buttons !== eb) begin n_err++; $display("FAIL release.buttons t=%0d got=%h want=%h", t, io.buttons, eb); end
            n_chk++; if (io.press_pulse !== 8'h00) begin n_err++; $display("FAIL release.pulse t=%0d got=%h want=00", t, io.press_pulse); end
        end
    endtask

    task automatic test_bounce;
        logic [4:0] pat;
        logic [7:0] eb, ep;
        pat = 5'b01101;  // 1,0,1,1,0 in time order
        for (int t = 0; t < 16; t++) begin
            io.raw_buttons[3] = (t < 5) ? pat[t] : 1'b0;
            @(negedge clock);
            n_chk++; if (io.buttons !== 8'h00 || io.press_pulse !== 8'h00) begin
                n_err++; $display("FAIL bounce.glitch t=%0d buttons=%h pulse=%h want=00/00", t, io.buttons, io.press_pulse); end
        end
        for (int t = 0; t < 14; t++) begin
            io.raw_buttons[3] = (t < 3);
            @(negedge clock);
            n_chk++; if (io.buttons !== 8'h00 || io.press_pulse !== 8'h00) begin
                n_err++; $display("FAIL bounce.short3 t=%0d buttons=%h pulse=%h want=00/00", t, io.buttons, io.press_pulse); end
        end
        for (int t = 0; t < 14; t++) begin
            io.raw_buttons[3] = (t < 4);
            @(negedge clock);
            eb = (t >= 5 && t < 9) ? 8'h08 : 8'h00;
            ep = (t == 5) ? 8'h08 : 8'h00;
            n_chk++; if (io.buttons !== eb) begin n_err++; $display("FAIL bounce.accept4 t=%0d got=%h want=%h", t, io.buttons, eb); end
            n_chk++; if (io.press_pulse !== ep) begin n_err++; $display("FAIL bounce.pulse4 t=%0d got=%h want=%h", t, io.press_pulse, ep); end
        end
    endtask

    task automatic test_multi;
        logic [7:0] eb, ep;
        io.raw_buttons = 8'hA5;
        for (int t = 0; t < 10; t++) begin
            @(negedge clock);
            eb = (t >= 5) ? 8'hA5 : 8'h00;
            ep = (t == 5) ? 8'hA5 : 8'h00;
            n_chk++; if (io.buttons !== eb) begin n_err++; $display("FAIL multi.buttons t=%0d got=%h want=%h", t, io.buttons, eb); end
            n_chk++; if (io.press_pulse !== ep) begin n_err++; $display("FAIL multi.pulse t=%0d got=%h want=%h", t, io.press_pulse, ep); end
        end
        io.raw_buttons = 8'h00;
        for (int t = 0; t < 10; t++) begin
            @(negedge clock);
            eb = (t >= 5) ? 8'h00 : 8'hA5;
            n_chk++; if (io.buttons !== eb || io.press_pulse !== 8'h00) begin
                n_err++; $display("FAIL multi.release t=%0d buttons=%h pulse=%h want=%h/00", t, io.buttons, io.press_pulse, eb); end
        end
    endtask

    task automatic test_start_holdoff;
        logic es, eh;
        int pulses;
        pulses = 0;
        for (int t = 0; t < 56; t++) begin
            io.raw_start = (t <= 7) || (t >= 14 && t <= 19) || (t >= 30 && t <= 37);
            @(negedge clock);
            es = (t == 5) || (t == 35);
            eh = (t >= 5 && t <= 20) || (t >= 35 && t <= 50);
            if (io.start_pulse === 1'b1) pulses++;
            n_chk++; if (io.start_pulse !== es) begin n_err++; $display("FAIL holdoff.start t=%0d got=%b want=%b", t, io.start_pulse, es); end
            n_chk++; if (io.holdoff_active !== eh) begin n_err++; $display("FAIL holdoff.active t=%0d got=%b want=%b", t, io.holdoff_active, eh); end
        end
        n_chk++; if (pulses != 2) begin n_err++; $display("FAIL holdoff.count got=%0d want=2", pulses); end
    endtask

    task automatic test_start_held;
        int pulses;
        pulses = 0;
        for (int t = 0; t < 110; t++) begin
            io.raw_start = (t < 100);
            @(negedge clock);
            if (io.start_pulse === 1'b1) pulses++;
            n_chk++; if (io.start_pulse !== (t == 5)) begin n_err++; $display("FAIL held.start t=%0d got=%b want=%b", t, io.start_pulse, (t == 5)); end
        end
        n_chk++; if (pulses != 1) begin n_err++; $display("FAIL held.count got=%0d want=1", pulses); end
    endtask

    task automatic test_async_reset;
        logic [7:0] eb, ep;
        // Start pulse lands at t=5, so hold-off reads 9 after edge 12; button 1 sampled from edge 9 has cnt=2.
        for (int t = 0; t <= 12; t++) begin
            io.raw_start   = 1'b1;
            io.raw_buttons = (t >= 9) ? 8'h03 : 8'h01;
            @(negedge clock);
        end
        n_chk++; if (io.buttons !== 8'h01 || io.holdoff_active !== 1'b1) begin
            n_err++; $display("FAIL areset.pre buttons=%h holdoff=%b want=01/1", io.buttons, io.holdoff_active); end
        #2 reset = 1'b1;
        #1;
        n_chk++; if (io.buttons !== 8'h00) begin n_err++; $display("FAIL areset.buttons got=%h want=00", io.buttons); end
        n_chk++; if (io.holdoff_active !== 1'b0) begin n_err++; $display("FAIL areset.holdoff got=%b want=0", io.holdoff_active); end
        n_chk++; if (io.press_pulse !== 8'h00 || io.start_pulse !== 1'b0) begin
            n_err++; $display("FAIL areset.pulses press=%h start=%b want=00/0", io.press_pulse, io.start_pulse); end
        io.raw_start   = 1'b0;
        io.raw_buttons = 8'h02;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clock);
            eb = (t >= 5) ? 8'h02 : 8'h00;
            ep = (t == 5) ? 8'h02 : 8'h00;
            n_chk++; if (io.buttons !== eb || io.press_pulse !== ep) begin
                n_err++; $display("FAIL areset.rearm t=%0d buttons=%h pulse=%h want=%h/%h", t, io.buttons, io.press_pulse, eb, ep); end
            n_chk++; if (io.holdoff_active !== 1'b0 || io.start_pulse !== 1'b0) begin
                n_err++; $display("FAIL areset.nostart t=%0d holdoff=%b start=%b want=0/0", t, io.holdoff_active, io.start_pulse); end
        end
        io.raw_start = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clock);
            n_chk++; if (io.start_pulse !== (t == 5) || io.holdoff_active !== (t >= 5)) begin
                n_err++; $display("FAIL areset.next_start t=%0d start=%b holdoff=%b want=%b/%b", t, io.start_pulse, io.holdoff_active, (t == 5), (t >= 5)); end
        end
        io.raw_start   = 1'b0;
        io.raw_buttons = 8'h00;
        repeat (25) @(negedge clock);
    endtask

    task automatic test_random;
        for (int i = 0; i < 800; i++) begin
            @(negedge clock);
            n_chk++; if (io.buttons !== m_clean[WIDTH-1:0]) begin n_err++; $display("FAIL rand.buttons i=%0d got=%h want=%h", i, io.buttons, m_clean[WIDTH-1:0]); end
            n_chk++; if (io.press_pulse !== m_press) begin n_err++; $display("FAIL rand.press i=%0d got=%h want=%h", i, io.press_pulse, m_press); end
            n_chk++; if (io.start_pulse !== m_start) begin n_err++; $display("FAIL rand.start i=%0d got=%b want=%b", i, io.start_pulse, m_start); end
            n_chk++; if (io.holdoff_active !== m_hold) begin n_err++; $display("FAIL rand.holdoff i=%0d got=%b want=%b", i, io.holdoff_active, m_hold); end
            if (reset) reset = 1'b0;
            if (i == 400) begin
                #2 reset = 1'b1;
                #1;
                n_chk++; if (io.buttons !== 8'h00 || io.press_pulse !== 8'h00 || io.start_pulse !== 1'b0 || io.holdoff_active !== 1'b0) begin
                    n_err++; $display("FAIL rand.areset buttons=%h press=%h start=%b holdoff=%b want=00/00/0/0",
                                      io.buttons, io.press_pulse, io.start_pulse, io.holdoff_active); end
            end else begin
                for (int b = 0; b < WIDTH; b++)
                    if ($urandom_range(0, 5) == 0) io.raw_buttons[b] = ~io.raw_buttons[b];
                if ($urandom_range(0, 9) == 0) io.raw_start = ~io.raw_start;
            end
        end
    endtask

    initial begin
        io.raw_buttons = '0;
        io.raw_start   = 1'b0;
        test_reset;
        test_clean_press;
        test_bounce;
        test_multi;
        test_start_holdoff;
        test_start_held;
        test_async_reset;
        test_random;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
